// File: rtl/iddmm_result_sel.sv
// Result selector for the Montgomery core: drains both result FIFOs after cal_done,
// forwards the N words picked by the sign flag on a valid/ready stream and discards the other N.
module iddmm_result_sel #(
  parameter int K     = 128,
  parameter int N     = 32,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cal_done,
  input  logic         cal_sign,
  input  logic         fifo_empty_a,
  input  logic [K-1:0] fifo_rd_data_a,
  output logic         fifo_rd_en_a,
  input  logic         fifo_empty_sub,
  input  logic [K-1:0] fifo_rd_data_sub,
  output logic         fifo_rd_en_sub,
  output logic         m_valid,
  output logic [K-1:0] m_data,
  output logic         m_last,
  input  logic         m_ready,
  output logic         busy,
  output logic         res_done,
  output logic         seq_err
);

  localparam logic [CNT_W-1:0] N_C    = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t           state;
  logic             sel;
  logic             last_acc;
  logic [CNT_W-1:0] fwd_cnt;
  logic [CNT_W-1:0] dis_cnt;

  logic             fwd_empty;
  logic             dis_empty;
  logic [K-1:0]     fwd_data;
  logic             fwd_pop;
  logic             dis_pop;
  logic             accept;
  logic             done_now;

  always_comb begin
    fwd_empty = sel ? fifo_empty_sub : fifo_empty_a;
    dis_empty = sel ? fifo_empty_a : fifo_empty_sub;
    fwd_data  = sel ? fifo_rd_data_sub : fifo_rd_data_a;
    accept    = m_valid && m_ready;
    fwd_pop   = (state == DRAIN) && !fwd_empty && (fwd_cnt < N_C) && (!m_valid || m_ready);
    dis_pop   = (state == DRAIN) && !dis_empty && (dis_cnt < N_C);
    // The final word may be accepted before the discard side finishes, so remember it.
    done_now  = last_acc || (accept && m_last);
  end

  assign fifo_rd_en_a   = sel ? dis_pop : fwd_pop;
  assign fifo_rd_en_sub = sel ? fwd_pop : dis_pop;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      last_acc <= 1'b0;
      fwd_cnt  <= '0;
      dis_cnt  <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      res_done <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      res_done <= 1'b0;
      if (cal_done && (state != IDLE)) seq_err <= 1'b1;

      // Output register: reload on pop (covers accept+pop with no bubble), empty on bare accept
      if (fwd_pop) begin
        m_valid <= 1'b1;
        m_data  <= fwd_data;
        m_last  <= (fwd_cnt == LAST_C);
      end else if (accept) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (fwd_pop) fwd_cnt <= fwd_cnt + 1'b1;
      if (dis_pop) dis_cnt <= dis_cnt + 1'b1;
      if (accept && m_last) last_acc <= 1'b1;

      case (state)
        IDLE: begin
          if (cal_done) begin
            sel      <= cal_sign;
            fwd_cnt  <= '0;
            dis_cnt  <= '0;
            last_acc <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if ((fwd_cnt == N_C) && (dis_cnt == N_C)) begin
            state    <= FLUSH;
            res_done <= done_now;
          end
        end
        FLUSH: begin
          if (res_done) state <= IDLE;
          else          res_done <= done_now;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Bench for iddmm_result_sel: queue-modelled FWFT FIFOs, scoreboard on the output stream.
module tb_iddmm_result_sel;
  localparam int K     = 32;
  localparam int N     = 4;
  localparam int CNT_W = $clog2(N) + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cal_done, cal_sign;
  logic         fifo_empty_a, fifo_empty_sub;
  logic [K-1:0] fifo_rd_data_a, fifo_rd_data_sub;
  logic         fifo_rd_en_a, fifo_rd_en_sub;
  logic         m_valid, m_last, m_ready;
  logic [K-1:0] m_data;
  logic         busy, res_done, seq_err;

  always #5 clk = ~clk;

  iddmm_result_sel #(.K(K), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cal_done(cal_done), .cal_sign(cal_sign),
    .fifo_empty_a(fifo_empty_a), .fifo_rd_data_a(fifo_rd_data_a), .fifo_rd_en_a(fifo_rd_en_a),
    .fifo_empty_sub(fifo_empty_sub), .fifo_rd_data_sub(fifo_rd_data_sub),
    .fifo_rd_en_sub(fifo_rd_en_sub),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .res_done(res_done), .seq_err(seq_err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [K-1:0] qa[$];
  logic [K-1:0] qs[$];
  logic [K-1:0] exp_w[N];
  int cyc = 0;
  int acc_cnt, pops_a, pops_s, last_acc_cyc, dis_done_cyc, exp_idx;
  bit dis_is_a;

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void upd();
    fifo_empty_a     = (qa.size() == 0);
    fifo_rd_data_a   = fifo_empty_a ? '0 : qa[0];
    fifo_empty_sub   = (qs.size() == 0);
    fifo_rd_data_sub = fifo_empty_sub ? '0 : qs[0];
  endfunction

  // One clock: sample pre-edge handshakes, then apply pops and score the stream.
  task automatic step();
    logic pa, ps, acc, stall, l;
    logic [K-1:0] d;
    @(posedge clk);
    pa = fifo_rd_en_a; ps = fifo_rd_en_sub;
    acc = m_valid && m_ready; stall = m_valid && !m_ready;
    d = m_data; l = m_last;
    #1;
    cyc++;
    if (pa) begin
      chk("pop_a_nonempty", qa.size() != 0, 1'b1);
      if (qa.size() != 0) void'(qa.pop_front());
      pops_a++;
      chk("pop_a_bound", pops_a <= N, 1'b1);
    end
    if (ps) begin
      chk("pop_sub_nonempty", qs.size() != 0, 1'b1);
      if (qs.size() != 0) void'(qs.pop_front());
      pops_s++;
      chk("pop_sub_bound", pops_s <= N, 1'b1);
    end
    if (dis_is_a ? (pa && pops_a == N) : (ps && pops_s == N)) dis_done_cyc = cyc;
    if (acc) begin
      chk("word_expected", exp_idx < N, 1'b1);
      if (exp_idx < N) chk("m_data", d, exp_w[exp_idx]);
      chk("m_last", l, exp_idx == N - 1);
      if (l) last_acc_cyc = cyc;
      exp_idx++;
      acc_cnt++;
    end
    if (stall) begin
      chk("hold_valid", m_valid, 1'b1);
      chk("hold_data", m_data, d);
      chk("hold_last", m_last, l);
    end
    upd();
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0, 2 random. gap: 0 preload, else one word per side every gap cycles.
  task automatic run_op(input bit sign, input int rmode, input int gap, input bit mid_cal,
                        input bit cal_at_done);
    logic [K-1:0] wa[N];
    logic [K-1:0] ws[N];
    int c0, pushed, exp_res;
    bit done;
    for (int i = 0; i < N; i++) begin
      wa[i] = $urandom;
      ws[i] = $urandom;
      exp_w[i] = sign ? ws[i] : wa[i];
    end
    exp_idx = 0; acc_cnt = 0; pops_a = 0; pops_s = 0;
    last_acc_cyc = -1; dis_done_cyc = -1; dis_is_a = sign;
    pushed = 0;
    if (gap == 0) begin
      for (int i = 0; i < N; i++) begin qa.push_back(wa[i]); qs.push_back(ws[i]); end
      pushed = N;
    end
    upd();
    m_ready = 1'b1; cal_sign = sign; cal_done = 1'b1;
    step();
    c0 = cyc;
    cal_done = 1'b0;
    chk("busy_start", busy, 1'b1);
    done = 0;
    for (int it = 0; it < 200 && !done; it++) begin
      if (gap > 0 && pushed < N && (it % gap) == 0) begin
        qa.push_back(wa[pushed]); qs.push_back(ws[pushed]); pushed++;
        upd();
      end
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((it % 3) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      cal_done = mid_cal && (it == 2);
      cal_sign = !sign;
      step();
      cal_done = 1'b0;
      if (mid_cal && it == 2) chk("seq_err_mid", seq_err, 1'b1);
      if (res_done) done = 1;
    end
    chk("res_done_seen", done, 1'b1);
    if (done) begin
      chk("accepted_words", acc_cnt, N);
      chk("pops_a", pops_a, N);
      chk("pops_sub", pops_s, N);
      chk("fifo_a_empty", qa.size(), 0);
      chk("fifo_sub_empty", qs.size(), 0);
      exp_res = (last_acc_cyc > dis_done_cyc + 1) ? last_acc_cyc : dis_done_cyc + 1;
      chk("res_done_time", cyc, exp_res);
      chk("busy_at_done", busy, 1'b1);
      if (gap == 0) chk("discard_time", dis_done_cyc - c0, N);
      if (gap == 0 && rmode == 0) chk("res_done_latency", cyc - c0, N + 1);
      m_ready = 1'b1;
      cal_done = cal_at_done; cal_sign = sign;
      step();
      cal_done = 1'b0;
      chk("res_done_pulse", res_done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      if (cal_at_done) chk("seq_err_at_done", seq_err, 1'b1);
      step();
      chk("idle_stays", busy, 1'b0);
      chk("idle_no_pop", {fifo_rd_en_a, fifo_rd_en_sub}, 2'b00);
    end
  endtask

  initial begin
    rst_n = 1'b0; cal_done = 1'b0; cal_sign = 1'b0; m_ready = 1'b0;
    exp_idx = 0; acc_cnt = 0; pops_a = 0; pops_s = 0; dis_is_a = 0;
    last_acc_cyc = -1; dis_done_cyc = -1;
    upd();
    step(); step();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_done", res_done, 1'b0);
    chk("rst_seq_err", seq_err, 1'b0);
    chk("rst_rd_en", {fifo_rd_en_a, fifo_rd_en_sub}, 2'b00);
    rst_n = 1'b1;
    step();

    run_op(1'b1, 0, 0, 1'b0, 1'b0);
    chk("seq_err_clean", seq_err, 1'b0);
    run_op(1'b0, 1, 0, 1'b0, 1'b0);
    run_op(1'b1, 1, 0, 1'b0, 1'b0);
    run_op(1'($urandom_range(0, 1)), 0, 3, 1'b0, 1'b0);
    run_op(1'b0, 0, 0, 1'b1, 1'b0);
    run_op(1'b1, 0, 0, 1'b0, 1'b0);
    chk("seq_err_sticky", seq_err, 1'b1);

    // Reset in the middle of an operation
    begin
      int guard = 0;
      for (int i = 0; i < N; i++) begin
        exp_w[i] = $urandom;
        qs.push_back(exp_w[i]);
        qa.push_back($urandom);
      end
      exp_idx = 0; acc_cnt = 0; pops_a = 0; pops_s = 0; dis_is_a = 1'b0;
      upd();
      m_ready = 1'b1; cal_sign = 1'b1; cal_done = 1'b1;
      step();
      cal_done = 1'b0;
      while (acc_cnt < 2 && guard < 20) begin step(); guard++; end
      chk("two_words_before_reset", acc_cnt, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_m_valid", m_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_res_done", res_done, 1'b0);
      chk("mid_rst_seq_err", seq_err, 1'b0);
      chk("mid_rst_rd_en", {fifo_rd_en_a, fifo_rd_en_sub}, 2'b00);
      qa.delete(); qs.delete();
      upd();
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_m_valid", m_valid, 1'b0);
    end

    run_op(1'b0, 0, 0, 1'b0, 1'b1);
    for (int r = 0; r < 6; r++)
      run_op(1'($urandom_range(0, 1)), 2, $urandom_range(0, 2), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/iddmm_result_sel.md
Name: iddmm_result_sel

Overview:
- Consumer end of the Montgomery calculation core's output interface.
- After the core pulses its done strobe, the block drains both result FIFOs:
  - the raw-result FIFO (a);
  - the subtracted-result FIFO (a − p, "sub").
- It forwards exactly N words of the FIFO chosen by the core's sign flag on a valid/ready stream, LSW first, and discards the N words of the other FIFO.
- Sits between the core and the exponentiation controller / result RAM.

Parameters:
- K, 128, bits per word.
- N, 32, words per operand/result.
- CNT_W, $clog2(N)+1, width of the word counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cal_done  in  1  single-cycle strobe from the core; the result sign is valid in the same cycle.
- cal_sign  in  1  1 = forward the sub FIFO; 0 = forward the a FIFO.
- fifo_empty_a  in  1  a FIFO empty (first-word-fall-through FIFO).
- fifo_rd_data_a  in  K  a FIFO head word.
- fifo_rd_en_a  out  1  pop the a FIFO.
- fifo_empty_sub  in  1  sub FIFO empty (first-word-fall-through FIFO).
- fifo_rd_data_sub  in  K  sub FIFO head word.
- fifo_rd_en_sub  out  1  pop the sub FIFO.
- m_valid  out  1  output word valid.
- m_data  out  K  output word.
- m_last  out  1  marks word N-1.
- m_ready  in  1  downstream accept.
- busy  out  1  high whenever state != IDLE.
- res_done  out  1  one-cycle pulse when the last word is accepted and the discard side is complete.
- seq_err  out  1  sticky; set by cal_done while busy; cleared only by reset.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; output register empty.
- FSM states: IDLE, DRAIN, FLUSH.
- IDLE:
  - Never pops either FIFO.
  - On cal_done: latch sel = cal_sign, clear both counters, go to DRAIN.
- DRAIN, forward side (selected FIFO):
  - One-entry registered output stage.
  - Pop the selected FIFO when it is non-empty, fwd_cnt < N, and (output register empty or m_valid && m_ready).
  - A popped word loads m_data the next cycle with m_valid=1; fwd_cnt increments on the pop.
  - m_last=1 with the word whose pop index is N-1.
  - m_data and m_last hold stable while m_valid && !m_ready.
  - Throughput: 1 word/cycle with m_ready held high. Latency from first pop to m_valid is 1 cycle.
- DRAIN, discard side (other FIFO):
  - Pop whenever the FIFO is non-empty and dis_cnt < N, independent of m_ready; dis_cnt increments per pop.
  - Data is ignored.
- FIFOs may still be filling when cal_done arrives. Each side waits on its empty flag and never pops an empty FIFO.
- Leave DRAIN for FLUSH when fwd_cnt == N and dis_cnt == N.
- FLUSH:
  - Waits for the final output word to be accepted (m_valid && m_ready with m_last).
  - Then res_done pulses for 1 cycle and the state returns to IDLE.
  - If that acceptance occurs in the same cycle DRAIN completes, pass through FLUSH in one cycle; res_done pulses the following cycle.
- Simultaneous events:
  - Accept and pop in the same cycle: the register reloads with no bubble.
  - cal_done in the same cycle as res_done/IDLE entry: ignored, and seq_err is set (the block is still busy that cycle).
- cal_done while busy: the operation in progress is unaffected and seq_err is set.
- Reset mid-operation: returns to IDLE immediately and drops m_valid. The external FIFOs are not flushed by this block; that is the system's responsibility.
- Counters never exceed N; no pops beyond N words per side per operation.

Test Plan:
- N=4, a FIFO = {A0..A3}, sub FIFO = {S0..S3} preloaded; cal_done with cal_sign=1; m_ready=1 → m_data S0,S1,S2,S3 on consecutive cycles, m_last on S3, both FIFOs empty, res_done 1 cycle after S3 is accepted.
- Same preload, cal_sign=0 → A0..A3 forwarded and the sub FIFO is fully discarded in 4 cycles regardless of m_ready.
- cal_sign=1, m_ready toggling 1,0,0,1,… → each word held stable while stalled; no loss or duplication; exactly 4 sub pops.
- FIFOs filled one word every 3 cycles after cal_done → no pop while empty; output order is preserved; res_done only after the 4th word of both sides.
- Second cal_done asserted mid-DRAIN → seq_err=1 (sticky); the current output sequence is unchanged; a later cal_done in IDLE starts normally.
- rst_n asserted after 2 words forwarded → m_valid=0, busy=0, res_done=0 immediately; seq_err cleared.
